led_scan_decoder: RTL and testbench

//   Receive-side companion to the segment encoder. Watches a scanned 7-seg display bus (segment pattern + active-low
//   one-hot digit select), filters glitches and decodes each stable pattern back to its 3-bit code.

---
 rtl/led_seg_pkg.sv | 38 +++
 rtl/led_seg_lookup.sv | 46 ++++
 rtl/led_scan_decoder.sv | 141 ++++++++++++++
 tb/tb_led_scan_decoder.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_seg_pkg.sv
// -----------------------------------------------------------------------------
// led_seg_pkg
//   Shared definitions for the 7-segment scan decoder:
//     seg_code_t   - 3-bit decoded digit code
//     CS_IDLE      - digit-select value with no digit driven (active-low bus)
//     SEG_PATTERN  - segment pattern for each code (index = code)
//     cs_to_index  - converts an active-low one-hot select into a digit index
//                    and reports whether exactly one digit is selected
// -----------------------------------------------------------------------------
package led_seg_pkg;

    typedef logic [2:0] seg_code_t;

    localparam logic [7:0] CS_IDLE = 8'hFF;

    // Code 7 is the blank digit (all segments off).
    localparam logic [7:0] SEG_PATTERN [0:7] = '{
        8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h00
    };

    function automatic void cs_to_index(
        input  logic [7:0] cs,
        output seg_code_t  idx,
        output logic       onehot_ok
    );
        int unsigned zeros;
        zeros = 0;
        idx   = '0;
        for (int i = 0; i < 8; i++) begin
            if (!cs[i]) begin
                zeros = zeros + 1;
                idx   = seg_code_t'(i);
            end
        end
        onehot_ok = (zeros == 1);
    endfunction

endpackage

// File: rtl/led_seg_lookup.sv
// -----------------------------------------------------------------------------
// led_seg_lookup
//   Combinational reverse lookup of a segment pattern into its 3-bit code.
//   Ports:
//     seg_i   [7:0]  segment pattern, bit7 = decimal point
//     hit_o          pattern is one of the eight known patterns
//     code_o  [2:0]  decoded code (0 when hit_o is low)
//   Configuration macro: LED_SCAN_DP_MASK_EN - when defined the decimal point
//   is ignored, otherwise a lit decimal point makes every pattern a miss.
// -----------------------------------------------------------------------------
module led_seg_lookup
    import led_seg_pkg::*;
(
    input  logic [7:0] seg_i,
    output logic       hit_o,
    output seg_code_t  code_o
);

    logic [7:0] seg_m;
    logic [7:0] match;

`ifdef LED_SCAN_DP_MASK_EN
    assign seg_m = {1'b0, seg_i[6:0]};
`else
    assign seg_m = seg_i;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_match
            assign match[gi] = (seg_m == SEG_PATTERN[gi]);
        end
    endgenerate

    // Table entries are unique, so at most one match bit is ever set.
    always_comb begin
        hit_o  = |match;
        code_o = '0;
        for (int i = 0; i < 8; i++) begin
            if (match[i]) begin
                code_o = seg_code_t'(i);
            end
        end
    end

endmodule

// File: rtl/led_scan_decoder.sv
// -----------------------------------------------------------------------------
// led_scan_decoder
//   Watches a scanned 7-segment bus, filters glitches, decodes each stable
//   pattern back to its code and stores it per digit position.
//   Parameters:
//     STABLE_CYCLES  identical synchronized samples needed before capture (1..255)
//     SYNC_STAGES    synchronizer depth on both input buses (2..4)
//   Ports:
//     clk, rst              clock, asynchronous active-high reset
//     smg_in      [7:0]     segment pattern, bit7 = decimal point
//     smg_cs_in   [7:0]     active-low one-hot digit select
//     digit_codes [23:0]    code of digit i on [3*i+2:3*i]
//     digit_valid [7:0]     digit i captured in the current frame
//     frame_done            1-cycle pulse when all 8 digits are captured
//     pattern_err           1-cycle pulse on a stable undecodable pattern
//     err_digit   [2:0]     digit index of the last pattern_err
//   Configuration macro: LED_SCAN_DP_MASK_EN (see led_seg_lookup).
// -----------------------------------------------------------------------------
module led_scan_decoder
    import led_seg_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int SYNC_STAGES   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  smg_in,
    input  logic [7:0]  smg_cs_in,
    output logic [23:0] digit_codes,
    output logic [7:0]  digit_valid,
    output logic        frame_done,
    output logic        pattern_err,
    output logic [2:0]  err_digit
);

    localparam logic [7:0] STABLE_W = 8'(STABLE_CYCLES);

    logic [SYNC_STAGES-1:0][7:0] seg_sync_q;
    logic [SYNC_STAGES-1:0][7:0] cs_sync_q;
    logic [7:0]  seg_s, cs_s;
    logic [7:0]  seg_prev_q, cs_prev_q;
    logic [7:0]  cnt_q, cnt_d;
    logic        captured_q, captured_d;
    logic [23:0] codes_q, codes_d;
    logic [7:0]  valid_q, valid_d;
    logic        frame_done_q, frame_done_d;
    logic        pattern_err_q;
    seg_code_t   err_digit_q, err_digit_d;

    logic        changed, capture, wr_hit, wr_miss;
    seg_code_t   cs_idx;
    logic        cs_ok;
    logic        lk_hit;
    seg_code_t   lk_code;
    logic [7:0]  slot_wr;

    assign seg_s = seg_sync_q[SYNC_STAGES-1];
    assign cs_s  = cs_sync_q[SYNC_STAGES-1];

    led_seg_lookup u_lookup (
        .seg_i  (seg_s),
        .hit_o  (lk_hit),
        .code_o (lk_code)
    );

    assign changed = ({seg_s, cs_s} != {seg_prev_q, cs_prev_q});

    always_comb begin
        if (changed) begin
            cnt_d = '0;
        end else if (cnt_q == STABLE_W) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
        cs_to_index(cs_s, cs_idx, cs_ok);
    end

    // The captured flag limits each dwell to a single capture even though the
    // saturated counter keeps reporting STABLE_CYCLES.
    assign capture = !changed && (cnt_d == STABLE_W) && !captured_q && cs_ok;
    assign wr_hit  = capture && lk_hit;
    assign wr_miss = capture && !lk_hit;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_slot_wr
            assign slot_wr[gi] = wr_hit && (cs_idx == seg_code_t'(gi));
        end
    endgenerate

    always_comb begin
        captured_d = changed ? 1'b0 : (captured_q | capture);
        // The mask is cleared the cycle after frame_done; a capture landing in
        // that same cycle survives as the only set bit.
        valid_d      = (frame_done_q ? 8'h00 : valid_q) | slot_wr;
        frame_done_d = wr_hit && (valid_d == 8'hFF);
        codes_d      = codes_q;
        for (int i = 0; i < 8; i++) begin
            if (slot_wr[i]) begin
                codes_d[3*i +: 3] = lk_code;
            end
        end
        err_digit_d = wr_miss ? cs_idx : err_digit_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_sync_q    <= '0;
            cs_sync_q     <= {SYNC_STAGES{CS_IDLE}};
            seg_prev_q    <= 8'h00;
            cs_prev_q     <= CS_IDLE;
            cnt_q         <= '0;
            captured_q    <= 1'b0;
            codes_q       <= '0;
            valid_q       <= '0;
            frame_done_q  <= 1'b0;
            pattern_err_q <= 1'b0;
            err_digit_q   <= '0;
        end else begin
            seg_sync_q    <= {seg_sync_q[SYNC_STAGES-2:0], smg_in};
            cs_sync_q     <= {cs_sync_q[SYNC_STAGES-2:0], smg_cs_in};
            seg_prev_q    <= seg_s;
            cs_prev_q     <= cs_s;
            cnt_q         <= cnt_d;
            captured_q    <= captured_d;
            codes_q       <= codes_d;
            valid_q       <= valid_d;
            frame_done_q  <= frame_done_d;
            pattern_err_q <= wr_miss;
            err_digit_q   <= err_digit_d;
        end
    end

    assign digit_codes = codes_q;
    assign digit_valid = valid_q;
    assign frame_done  = frame_done_q;
    assign pattern_err = pattern_err_q;
    assign err_digit   = err_digit_q;

endmodule

// File: tb/tb_led_scan_decoder.sv
// -----------------------------------------------------------------------------
// tb_led_scan_decoder
//   Scoreboard bench: every dwell long enough to be captured pushes its
//   expected event (hit/miss, digit, code, due cycle); a negedge monitor pops
//   and compares whenever the DUT writes a slot or pulses pattern_err.
// -----------------------------------------------------------------------------
module tb_led_scan_decoder;

    localparam int SYNC      = 2;
    localparam int STABLE    = 4;
    localparam int LAT       = SYNC + STABLE + 1;
    localparam int MIN_DWELL = SYNC + STABLE - 1;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  smg_in;
    logic [7:0]  smg_cs_in;
    logic [23:0] digit_codes;
    logic [7:0]  digit_valid;
    logic        frame_done;
    logic        pattern_err;
    logic [2:0]  err_digit;

    led_scan_decoder #(
        .STABLE_CYCLES (STABLE),
        .SYNC_STAGES   (SYNC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .smg_in      (smg_in),
        .smg_cs_in   (smg_cs_in),
        .digit_codes (digit_codes),
        .digit_valid (digit_valid),
        .frame_done  (frame_done),
        .pattern_err (pattern_err),
        .err_digit   (err_digit)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit is_err;
        int idx;
        int code;
        int due;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          hit_cnt = 0;
    int          err_cnt = 0;
    int          frame_cnt = 0;
    logic [7:0]  prev_valid = 8'h00;
    logic [15:0] last_pat = 16'hFF00;
    logic [7:0]  seg_tab [0:7] = '{8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h00};

    always @(posedge clk) cyc++;

    function automatic void model_decode(input logic [7:0] seg, output bit hit, output int code);
        logic [7:0] s;
        s = seg;
`ifdef LED_SCAN_DP_MASK_EN
        s[7] = 1'b0;
`endif
        hit = 1'b1;
        case (s)
            8'h06:   code = 0;
            8'h5B:   code = 1;
            8'h4F:   code = 2;
            8'h66:   code = 3;
            8'h6D:   code = 4;
            8'h7D:   code = 5;
            8'h07:   code = 6;
            8'h00:   code = 7;
            default: begin hit = 1'b0; code = 0; end
        endcase
    endfunction

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 8'h00;
        end else begin
            while (sb_q.size() > 0 && sb_q[0].due < cyc) begin
                checks++; errors++;
                $display("FAIL sb_missing digit=%0d got no output, required at cycle %0d (now %0d)",
                         sb_q[0].idx, sb_q[0].due, cyc);
                void'(sb_q.pop_front());
            end
            for (int i = 0; i < 8; i++) begin
                if (digit_valid[i] && !prev_valid[i]) begin
                    hit_cnt++;
                    checks++;
                    if (sb_q.size() == 0) begin
                        errors++;
                        $display("FAIL sb_unexpected_write got digit=%0d code=%0d cycle=%0d, required no write",
                                 i, digit_codes[3*i +: 3], cyc);
                    end else begin
                        exp_t e;
                        e = sb_q.pop_front();
                        if (e.is_err !== 1'b0 || e.idx != i || e.code != int'(digit_codes[3*i +: 3]) || e.due != cyc) begin
                            errors++;
                            $display("FAIL sb_write got write digit=%0d code=%0d cycle=%0d, required err=%0d digit=%0d code=%0d cycle=%0d",
                                     i, digit_codes[3*i +: 3], cyc, e.is_err, e.idx, e.code, e.due);
                        end else begin
                            $display("write digit=%0d code=%0d cycle=%0d ok", i, digit_codes[3*i +: 3], cyc);
                        end
                    end
                end
            end
            if (pattern_err) begin
                err_cnt++;
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected_err got err_digit=%0d cycle=%0d, required no error", err_digit, cyc);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    if (e.is_err !== 1'b1 || e.idx != int'(err_digit) || e.due != cyc) begin
                        errors++;
                        $display("FAIL sb_err got error digit=%0d cycle=%0d, required err=%0d digit=%0d cycle=%0d",
                                 err_digit, cyc, e.is_err, e.idx, e.due);
                    end else begin
                        $display("error digit=%0d cycle=%0d ok", err_digit, cyc);
                    end
                end
            end
            if (frame_done) begin
                frame_cnt++;
                checks++;
                if (digit_valid !== 8'hFF) begin
                    errors++;
                    $display("FAIL frame_mask got valid=%h at frame_done, required ff", digit_valid);
                end
            end
            prev_valid = digit_valid;
        end
    end

    // Hold {cs,seg} for n clocks starting at the current negedge.
    task automatic drive(input logic [7:0] cs, input logic [7:0] seg, input int n);
        exp_t e;
        bit   h;
        int   c;
        int   zeros;
        int   idx;
        smg_cs_in = cs;
        smg_in    = seg;
        zeros = 0;
        idx   = 0;
        for (int i = 0; i < 8; i++) begin
            if (!cs[i]) begin
                zeros++;
                idx = i;
            end
        end
        if ({cs, seg} != last_pat && n >= MIN_DWELL && zeros == 1) begin
            model_decode(seg, h, c);
            e.is_err = !h;
            e.idx    = idx;
            e.code   = h ? c : 0;
            e.due    = cyc + LAT;
            sb_q.push_back(e);
        end
        last_pat = {cs, seg};
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        smg_cs_in = 8'hFF;
        smg_in    = 8'h00;
        sb_q.delete();
        last_pat  = 16'hFF00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (digit_codes !== 24'h0 || digit_valid !== 8'h00 || frame_done !== 1'b0 ||
            pattern_err !== 1'b0 || err_digit !== 3'd0) begin
            errors++;
            $display("FAIL reset_state got codes=%h valid=%h fd=%b perr=%b ed=%0d, required all zero",
                     digit_codes, digit_valid, frame_done, pattern_err, err_digit);
        end
        repeat (50) @(negedge clk);
        checks++;
        if (digit_codes !== 24'h0 || digit_valid !== 8'h00 || frame_cnt != 0 || err_cnt != 0) begin
            errors++;
            $display("FAIL idle_quiet got codes=%h valid=%h frames=%0d errs=%0d, required 0 0 0 0",
                     digit_codes, digit_valid, frame_cnt, err_cnt);
        end
        $display("test_reset done");
    endtask

    task automatic test_single();
        int h0;
        do_reset();
        h0 = hit_cnt;
        drive(8'hFE, 8'h4F, 12);
        checks++;
        if (digit_codes[2:0] !== 3'd2 || digit_valid !== 8'h01) begin
            errors++;
            $display("FAIL single_capture got code0=%0d valid=%h, required 2 01", digit_codes[2:0], digit_valid);
        end
        checks++;
        if (hit_cnt - h0 != 1 || sb_q.size() != 0) begin
            errors++;
            $display("FAIL single_count got writes=%0d pending=%0d, required 1 0", hit_cnt - h0, sb_q.size());
        end
        $display("test_single done");
    endtask

    task automatic test_frame();
        int         f0;
        logic [7:0] cs;
        do_reset();
        f0 = frame_cnt;
        for (int i = 0; i < 8; i++) begin
            cs = 8'hFF;
            cs[i] = 1'b0;
            drive(cs, seg_tab[i], 10);
        end
        drive(8'hFF, 8'h00, 4);
        checks++;
        if (frame_cnt - f0 != 1) begin
            errors++;
            $display("FAIL frame_pulses got %0d, required 1", frame_cnt - f0);
        end
        checks++;
        if (digit_codes !== 24'hFAC688 || digit_valid !== 8'h00) begin
            errors++;
            $display("FAIL frame_result got codes=%h valid=%h, required fac688 00", digit_codes, digit_valid);
        end
        $display("test_frame done");
    endtask

    task automatic test_glitch();
        int h0;
        h0 = hit_cnt;
        drive(8'hF7, 8'h66, 3);
        drive(8'hF7, 8'h5B, 10);
        checks++;
        if (digit_codes[11:9] !== 3'd1 || hit_cnt - h0 != 1 || digit_valid !== 8'h08) begin
            errors++;
            $display("FAIL glitch got code3=%0d writes=%0d valid=%h, required 1 1 08",
                     digit_codes[11:9], hit_cnt - h0, digit_valid);
        end
        $display("test_glitch done");
    endtask

    task automatic test_error();
        int         e0;
        logic [2:0] slot5;
        e0    = err_cnt;
        slot5 = digit_codes[17:15];
        drive(8'hDF, 8'hFF, 10);
        checks++;
        if (err_digit !== 3'd5 || digit_codes[17:15] !== slot5 || err_cnt - e0 != 1 || digit_valid[5] !== 1'b0) begin
            errors++;
            $display("FAIL bad_pattern got ed=%0d slot5=%0d errs=%0d v5=%b, required 5 %0d 1 0",
                     err_digit, digit_codes[17:15], err_cnt - e0, digit_valid[5], slot5);
        end
        drive(8'hDF, 8'h86, 10);
`ifdef LED_SCAN_DP_MASK_EN
        checks++;
        if (digit_codes[17:15] !== 3'd0 || digit_valid[5] !== 1'b1 || err_cnt - e0 != 1) begin
            errors++;
            $display("FAIL dp_masked got slot5=%0d v5=%b errs=%0d, required 0 1 1",
                     digit_codes[17:15], digit_valid[5], err_cnt - e0);
        end
`else
        checks++;
        if (digit_codes[17:15] !== slot5 || digit_valid[5] !== 1'b0 || err_cnt - e0 != 2 || err_digit !== 3'd5) begin
            errors++;
            $display("FAIL dp_error got slot5=%0d v5=%b errs=%0d ed=%0d, required %0d 0 2 5",
                     digit_codes[17:15], digit_valid[5], err_cnt - e0, err_digit, slot5);
        end
`endif
        $display("test_error done");
    endtask

    task automatic test_reset_mid();
        int         h0;
        int         e0;
        logic [7:0] cs;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cs = 8'hFF;
            cs[i] = 1'b0;
            drive(cs, seg_tab[i], 10);
        end
        checks++;
        if (digit_valid !== 8'h0F) begin
            errors++;
            $display("FAIL mid_frame_mask got valid=%h, required 0f", digit_valid);
        end
        #2;
        rst = 1'b1;
        sb_q.delete();
        last_pat = 16'hFF00;
        #1;
        checks++;
        if (digit_codes !== 24'h0 || digit_valid !== 8'h00 || err_digit !== 3'd0) begin
            errors++;
            $display("FAIL async_reset got codes=%h valid=%h ed=%0d, required 0 0 0",
                     digit_codes, digit_valid, err_digit);
        end
        @(negedge clk);
        rst = 1'b0;
        h0 = hit_cnt;
        e0 = err_cnt;
        drive(8'hFC, 8'h06, 15);
        checks++;
        if (hit_cnt != h0 || err_cnt != e0 || digit_valid !== 8'h00) begin
            errors++;
            $display("FAIL two_low_cs got writes=%0d errs=%0d valid=%h, required 0 0 00",
                     hit_cnt - h0, err_cnt - e0, digit_valid);
        end
        drive(8'hFE, 8'h06, 10);
        checks++;
        if (hit_cnt - h0 != 1 || digit_valid !== 8'h01 || digit_codes[2:0] !== 3'd0) begin
            errors++;
            $display("FAIL post_reset_capture got writes=%0d valid=%h code0=%0d, required 1 01 0",
                     hit_cnt - h0, digit_valid, digit_codes[2:0]);
        end
        $display("test_reset_mid done");
    endtask

    initial begin
        rst       = 1'b1;
        smg_in    = 8'h00;
        smg_cs_in = 8'hFF;
        test_reset();
        test_single();
        test_frame();
        test_glitch();
        test_error();
        test_reset_mid();
        drive(8'hFF, 8'h00, 10);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain got %0d pending events, required 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
